// File: rtl/imem_boot_ctrl.sv
// Boot controller for the instruction memory: clears every word after reset,
// loads a program from a streaming port, then hands the read port to fetch.
module imem_boot_ctrl #(
  parameter int SIZE       = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_stall,
  output logic                  fetch_fault,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_W-1:0]     mem_raddr,
  output logic [ADDR_W:0]       load_count,
  output logic                  load_err
);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              last_slot;
  logic              beat;
  logic              fault_raw;

  assign last_slot = (ptr == ADDR_W'(SIZE - 1));
  // A load_start in the same cycle wins over a LOAD beat: the word is dropped.
  assign beat      = (state == S_LOAD) && load_valid && !load_start;
  assign fault_raw = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:2] >= 30'(SIZE));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nx;
  end

  // Next-state: clear sweep, load until last beat or memory full, then run
  always_comb begin
    state_nx = state;
    if (load_start) begin
      state_nx = S_CLEAR;
    end else begin
      case (state)
        S_CLEAR: if (last_slot) state_nx = S_LOAD;
        S_LOAD:  if (beat && (load_last || last_slot)) state_nx = S_RUN;
        S_RUN:   state_nx = S_RUN;
        default: state_nx = S_CLEAR;
      endcase
    end
  end

  // Write pointer, word counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      ptr        <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: ptr <= last_slot ? '0 : ptr + 1'b1;
        S_LOAD: begin
          if (beat) begin
            ptr <= last_slot ? '0 : ptr + 1'b1;
            if (load_count != (ADDR_W+1)'(SIZE)) load_count <= load_count + 1'b1;
            if (last_slot && !load_last) load_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state; only fetch decode and the load
  // write path see inputs combinationally
  always_comb begin
    load_ready  = 1'b0;
    fetch_stall = 1'b1;
    fetch_fault = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ptr;
    mem_wdata   = '0;
    mem_raddr   = '0;
    case (state)
      S_CLEAR: mem_we = 1'b1;
      S_LOAD: begin
        load_ready = 1'b1;
        mem_we     = beat;
        mem_wdata  = load_data;
      end
      S_RUN: begin
        fetch_stall = 1'b0;
        fetch_fault = fault_raw;
        mem_raddr   = fault_raw ? '0 : fetch_addr[ADDR_W+1:2];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl: a phase/queue model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_imem_boot_ctrl;
  localparam int SIZE = 32;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic          clk, reset;
  logic          load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic [31:0]   fetch_addr;
  logic          fetch_stall, fetch_fault, mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   load_count;
  logic          load_err;

  imem_boot_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .fetch_fault(fetch_fault),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .load_count(load_count), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = clearing, 1 = loading, 2 = running
  int          phase;
  int          cleared;
  logic [31:0] prog[$];
  bit          err;
  bit          model_on = 1'b0;
  logic [31:0] shadow[SIZE];

  int          e_cnt;
  bit          e_we, e_flt;
  logic [31:0] e_addr, e_data, e_raddr;

  // Inputs change only just after posedge, so at negedge they are exactly
  // what the next edge samples: compare first, then advance the model.
  always @(negedge clk) begin
    if (model_on) begin
      e_we   = (phase == 0) || (phase == 1 && load_valid && !load_start);
      e_addr = (phase == 0) ? cleared : prog.size();
      e_data = (phase == 0) ? 32'h0 : load_data;
      e_flt  = (phase == 2) && ((fetch_addr % 4) != 0 || (fetch_addr / 4) >= SIZE);
      e_raddr = (phase == 2 && !e_flt) ? fetch_addr / 4 : 0;
      e_cnt  = (prog.size() > SIZE) ? SIZE : prog.size();
      chk("fetch_stall", fetch_stall, phase != 2);
      chk("load_ready", load_ready, phase == 1);
      chk("mem_we", mem_we, e_we);
      if (e_we) begin
        chk("mem_waddr", mem_waddr, e_addr);
        chk("mem_wdata", mem_wdata, e_data);
      end
      chk("fetch_fault", fetch_fault, e_flt);
      chk("mem_raddr", mem_raddr, e_raddr);
      chk("load_count", load_count, e_cnt);
      chk("load_err", load_err, err);
    end
    if (mem_we) shadow[mem_waddr] = mem_wdata;
    if (reset || (model_on && load_start)) begin
      model_on = 1'b1;
      phase = 0; cleared = 0; err = 1'b0;
      prog.delete();
    end else if (model_on) begin
      if (phase == 0) begin
        cleared++;
        if (cleared == SIZE) begin phase = 1; cleared = 0; end
      end else if (phase == 1 && load_valid) begin
        prog.push_back(load_data);
        if (load_last) phase = 2;
        else if (prog.size() == SIZE) begin phase = 2; err = 1'b1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic l);
    load_valid = v; load_data = d; load_last = l;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  function automatic logic [31:0] rand_fa();
    logic [31:0] a;
    if ($urandom_range(0, 4) == 0) a = $urandom;
    else a = ($urandom_range(0, 40) << 2) | (($urandom_range(0, 6) == 0) ? 32'd2 : 32'd0);
    return a;
  endfunction

  task automatic wait_ready();
    for (int k = 0; k < 100 && !load_ready; k++) tick();
    chk("ready_timeout", load_ready, 1'b1);
  endtask

  logic [31:0] words[3];

  initial begin
    words[0] = 32'h20090000; words[1] = 32'h01095020; words[2] = 32'h08000002;
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_addr = '0;
    repeat (2) tick();
    reset = 1'b0;
    // T1: clear sweep takes exactly SIZE cycles
    chk("t1_reset_count", load_count, 0);
    chk("t1_reset_err", load_err, 0);
    chk("t1_first_waddr", mem_waddr, 0);
    repeat (31) tick();
    chk("t1_last_clear_waddr", mem_waddr, 31);
    chk("t1_ready_before", load_ready, 0);
    tick();
    chk("t1_ready_after", load_ready, 1);
    repeat (3) tick();
    chk("t1_stays_load", load_ready, 1);
    // T2/T3: three words with gaps in load_valid
    beat(1'b1, words[0], 1'b0);
    beat(1'b0, 32'hdeadbeef, 1'b1);
    beat(1'b1, words[1], 1'b0);
    beat(1'b0, 32'hdeadbeef, 1'b0);
    beat(1'b1, words[2], 1'b1);
    chk("t2_count", load_count, 3);
    chk("t2_err", load_err, 0);
    chk("t2_stall", fetch_stall, 0);
    chk("t2_mem0", shadow[0], 32'h20090000);
    chk("t2_mem1", shadow[1], 32'h01095020);
    chk("t2_mem2", shadow[2], 32'h08000002);
    chk("t2_mem3_cleared", shadow[3], 0);
    // T5: fetch decode
    fetch_addr = 32'h24; #1;
    chk("t5_raddr_24", mem_raddr, 9); chk("t5_fault_24", fetch_fault, 0);
    fetch_addr = 32'h26; #1;
    chk("t5_raddr_26", mem_raddr, 0); chk("t5_fault_26", fetch_fault, 1);
    fetch_addr = 32'h80; #1;
    chk("t5_raddr_80", mem_raddr, 0); chk("t5_fault_80", fetch_fault, 1);
    fetch_addr = 32'h7c; #1;
    chk("t5_raddr_7c", mem_raddr, 31); chk("t5_fault_7c", fetch_fault, 0);
    for (int k = 0; k < 20; k++) begin fetch_addr = rand_fa(); tick(); end
    // T6: load_start in RUN restarts the clear sweep
    fetch_addr = 32'h24;
    load_start = 1'b1; #1;
    chk("t6_decode_same_cycle", mem_raddr, 9);
    tick();
    load_start = 1'b0;
    chk("t6_stall", fetch_stall, 1);
    chk("t6_count", load_count, 0);
    chk("t6_waddr0", mem_waddr, 0);
    repeat (32) tick();
    // T4: 32 beats without load_last, then an ignored 33rd
    for (int k = 0; k < SIZE; k++) beat(1'b1, $urandom, 1'b0);
    chk("t4_err", load_err, 1);
    chk("t4_count", load_count, 32);
    chk("t4_ready", load_ready, 0);
    load_valid = 1'b1; load_data = 32'hffffffff; #1;
    chk("t4_extra_we", mem_we, 0);
    tick();
    load_valid = 1'b0;
    chk("t4_count_hold", load_count, 32);
    // T6b: reset in the middle of a load
    load_start = 1'b1; tick(); load_start = 1'b0;
    repeat (32) tick();
    for (int k = 0; k < 5; k++) beat(1'b1, $urandom, 1'b0);
    chk("t6_mid_count", load_count, 5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_rst_err", load_err, 0);
    chk("t6_rst_count", load_count, 0);
    chk("t6_rst_waddr", mem_waddr, 0);
    chk("t6_rst_we", mem_we, 1);
    // Randomized load/run cycles, checked by the model every cycle
    for (int it = 0; it < 8; it++) begin
      int len, sent, guard;
      bit ls;
      wait_ready();
      len = $urandom_range(1, 34);
      sent = 0; guard = 0;
      while (sent < len && guard < 200) begin
        ls = ($urandom_range(0, 60) == 0);
        load_start = ls;
        load_valid = ($urandom_range(0, 2) != 0);
        load_data  = $urandom;
        load_last  = (sent == len - 1);
        fetch_addr = rand_fa();
        tick();
        if (load_valid) sent++;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        guard++;
        if (ls) break;
      end
      for (int k = 0; k < 8; k++) begin fetch_addr = rand_fa(); tick(); end
      if ($urandom_range(0, 3) == 0) begin reset = 1'b1; tick(); reset = 1'b0; end
      else begin load_start = 1'b1; tick(); load_start = 1'b0; end
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
